// File: rtl/iu_prefetch_if.sv
// Bundles the BIU instruction port, the redirect input and the EXU issue port of the prefetch unit.
// The prefetch unit connects through the master modport.
interface iu_prefetch_if #(
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_rdy;
    logic [31:0]   fetch_data;
    logic          fetch_err;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          iss_valid;
    logic          iss_ready;
    logic [31:0]   iss_ins;
    logic [31:0]   iss_pc;
    logic [1:0]    iss_cause;
    logic          iss_mem;
    logic [CW-1:0] q_count;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_rdy, fetch_data, fetch_err,
        input  redirect_valid, redirect_pc,
        output iss_valid, iss_ins, iss_pc, iss_cause, iss_mem, q_count,
        input  iss_ready
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_rdy, fetch_data, fetch_err,
        output redirect_valid, redirect_pc,
        input  iss_valid, iss_ins, iss_pc, iss_cause, iss_mem, q_count,
        output iss_ready
    );
endinterface

// File: rtl/iu_prefetch.sv
// Fetch/pre-decode front end: single-outstanding fetch, QDEPTH-entry prefetch queue,
// redirectable fetch PC, and pre-decoded cause/mem tags on every queued word.
module iu_prefetch #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          HAS_MUL  = 1'b0
) (
    input logic           clk,
    input logic           rst,
    iu_prefetch_if.master pf
);
    localparam int unsigned   PW   = $clog2(QDEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISAL   = 2'b01;
    localparam logic [1:0] CAUSE_FAULT   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MISAL = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic        mem;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        slot_q [QDEPTH];

    logic   iss_valid;
    logic   pop;
    logic   pop_eff;
    logic   push;
    logic   fetch_req;
    logic   fetch_done;
    entry_t ent;
    entry_t head;

    function automatic logic is_legal(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        is_legal = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_MISC: is_legal = 1'b1;
            OP_JALR:   is_legal = (f3 == 3'b000);
            OP_BRANCH: is_legal = !(f3 == 3'b010 || f3 == 3'b011);
            OP_LOAD:   is_legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OP_STORE:  is_legal = f3 inside {3'b000, 3'b001, 3'b010};
            OP_IMM: begin
                if (f3 == 3'b001)      is_legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) is_legal = (f7 == 7'b0000000 || f7 == 7'b0100000);
                else                   is_legal = 1'b1;
            end
            OP_OP: begin
                if (f7 == 7'b0000000)      is_legal = 1'b1;
                else if (f7 == 7'b0100000) is_legal = (f3 == 3'b000 || f3 == 3'b101);
                else if (f7 == 7'b0000001) is_legal = HAS_MUL;
                else                       is_legal = 1'b0;
            end
            OP_SYSTEM: is_legal = (f3 != 3'b100);
            default:   is_legal = 1'b0;
        endcase
    endfunction

    assign iss_valid = (count_q != '0);
    assign pop       = iss_valid & pf.iss_ready;
    // A pop frees a slot this cycle, so a full queue may still request.
    assign fetch_req  = !rst && (state_q == S_RUN) && ((count_q != FULL) || pop);
    assign fetch_done = fetch_req & pf.fetch_rdy;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        push      = 1'b0;
        pop_eff   = pop;
        ent.ins   = pf.fetch_data;
        ent.pc    = pc_q;
        ent.cause = CAUSE_NONE;
        ent.mem   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (fetch_done) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (pf.fetch_err) begin
                        ent.cause = CAUSE_FAULT;
                        state_d   = S_HALT;
                    end else begin
                        ent.cause = is_legal(pf.fetch_data) ? CAUSE_NONE : CAUSE_ILLEGAL;
                        ent.mem   = (pf.fetch_data[6:0] == OP_LOAD) ||
                                    (pf.fetch_data[6:0] == OP_STORE);
                    end
                end
            end
            S_MISAL: begin
                push      = 1'b1;
                ent.ins   = '0;
                ent.cause = CAUSE_MISAL;
                state_d   = S_HALT;
            end
            default: ;
        endcase
        // Redirect overrides any completing fetch and any pop.
        if (pf.redirect_valid) begin
            push    = 1'b0;
            pop_eff = 1'b0;
            pc_d    = pf.redirect_pc;
            state_d = (pf.redirect_pc[1:0] == 2'b00) ? S_RUN : S_MISAL;
        end
    end

    always_comb begin
        if (pf.redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop_eff);
            rd_ptr_d = rd_ptr_q + PW'(pop_eff);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            slot_q[wr_ptr_q] <= ent;
        end
    end

    // Storage is not reset; gating on iss_valid keeps the issue port zero when empty.
    assign head = slot_q[rd_ptr_q];

    assign pf.fetch_req  = fetch_req;
    assign pf.fetch_addr = pc_q;
    assign pf.iss_valid  = iss_valid;
    assign pf.iss_ins    = iss_valid ? head.ins   : 32'd0;
    assign pf.iss_pc     = iss_valid ? head.pc    : 32'd0;
    assign pf.iss_cause  = iss_valid ? head.cause : 2'b00;
    assign pf.iss_mem    = iss_valid ? head.mem   : 1'b0;
    assign pf.q_count    = count_q;
endmodule

// File: tb/tb_iu_prefetch.sv
// Directed bench for iu_prefetch: cycle table for streaming/backpressure/redirect plus
// hand sequences for redirect-with-completion, misaligned redirect, fetch fault and reset.
module tb_iu_prefetch;
    localparam logic [31:0] W_ADDI = 32'h0010_0093;
    localparam logic [31:0] W_LW   = 32'h0000_2003;
    localparam logic [31:0] W_MUL  = 32'h0220_8033;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_rdy = 1'b0;
    logic [31:0] fetch_data = 32'd0;
    logic        fetch_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        iss_ready = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iu_prefetch_if #(.QDEPTH(4)) ifa ();
    iu_prefetch_if #(.QDEPTH(4)) ifb ();

    assign ifa.fetch_rdy      = fetch_rdy;
    assign ifa.fetch_data     = fetch_data;
    assign ifa.fetch_err      = fetch_err;
    assign ifa.redirect_valid = redirect_valid;
    assign ifa.redirect_pc    = redirect_pc;
    assign ifa.iss_ready      = iss_ready;
    assign ifb.fetch_rdy      = fetch_rdy;
    assign ifb.fetch_data     = fetch_data;
    assign ifb.fetch_err      = fetch_err;
    assign ifb.redirect_valid = redirect_valid;
    assign ifb.redirect_pc    = redirect_pc;
    assign ifb.iss_ready      = iss_ready;

    iu_prefetch #(.QDEPTH(4), .RESET_PC(32'h0), .HAS_MUL(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .pf  (ifa.master)
    );

    iu_prefetch #(.QDEPTH(4), .RESET_PC(32'h0), .HAS_MUL(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .pf  (ifb.master)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
        logic        ird;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [1:0]  e_cause_a;
        logic [1:0]  e_cause_b;
        logic        e_mem;
        logic [2:0]  e_qc;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic rdy, input logic [31:0] data, input logic rv,
                                input logic [31:0] rpc, input logic ird, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_ins,
                                input logic [1:0] e_cause_a, input logic [1:0] e_cause_b,
                                input logic e_mem, input logic [2:0] e_qc);
        vec_t v;
        v.rdy = rdy; v.data = data; v.rv = rv; v.rpc = rpc; v.ird = ird;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_ins = e_ins; v.e_cause_a = e_cause_a; v.e_cause_b = e_cause_b;
        v.e_mem = e_mem; v.e_qc = e_qc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming, lw/mul tagging, redirect to 0, backpressure to full, release.
        vecs[0]  = mk(1, W_ADDI, 0, 0, 1,  1, 32'h00, 0, 32'h00, 32'd0,  2'd0, 2'd0, 0, 3'd0);
        vecs[1]  = mk(1, W_LW,   0, 0, 1,  1, 32'h04, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd1);
        vecs[2]  = mk(1, W_MUL,  0, 0, 1,  1, 32'h08, 1, 32'h04, W_LW,   2'd0, 2'd0, 1, 3'd1);
        vecs[3]  = mk(1, W_ADDI, 0, 0, 1,  1, 32'h0C, 1, 32'h08, W_MUL,  2'd3, 2'd0, 0, 3'd1);
        vecs[4]  = mk(1, W_ADDI, 1, 0, 1,  1, 32'h10, 1, 32'h0C, W_ADDI, 2'd0, 2'd0, 0, 3'd1);
        vecs[5]  = mk(1, W_ADDI, 0, 0, 0,  1, 32'h00, 0, 32'h00, 32'd0,  2'd0, 2'd0, 0, 3'd0);
        vecs[6]  = mk(1, W_ADDI, 0, 0, 0,  1, 32'h04, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd1);
        vecs[7]  = mk(1, W_ADDI, 0, 0, 0,  1, 32'h08, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd2);
        vecs[8]  = mk(1, W_ADDI, 0, 0, 0,  1, 32'h0C, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd3);
        vecs[9]  = mk(1, W_ADDI, 0, 0, 0,  0, 32'h10, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[10] = mk(0, W_ADDI, 0, 0, 0,  0, 32'h10, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[11] = mk(1, W_ADDI, 0, 0, 1,  1, 32'h10, 1, 32'h00, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[12] = mk(1, W_ADDI, 0, 0, 1,  1, 32'h14, 1, 32'h04, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[13] = mk(1, W_ADDI, 0, 0, 1,  1, 32'h18, 1, 32'h08, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[14] = mk(1, W_ADDI, 0, 0, 1,  1, 32'h1C, 1, 32'h0C, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[15] = mk(0, W_ADDI, 0, 0, 1,  1, 32'h20, 1, 32'h10, W_ADDI, 2'd0, 2'd0, 0, 3'd4);
        vecs[16] = mk(0, W_ADDI, 0, 0, 1,  1, 32'h20, 1, 32'h14, W_ADDI, 2'd0, 2'd0, 0, 3'd3);

        // Reset state, checked while rst is still asserted.
        adv();
        adv();
        @(negedge clk);
        chk("rst fetch_req", 32'(ifa.fetch_req), 32'd0);
        chk("rst iss_valid", 32'(ifa.iss_valid), 32'd0);
        chk("rst iss_ins", ifa.iss_ins, 32'd0);
        chk("rst iss_pc", ifa.iss_pc, 32'd0);
        chk("rst iss_cause", 32'(ifa.iss_cause), 32'd0);
        chk("rst iss_mem", 32'(ifa.iss_mem), 32'd0);
        chk("rst q_count", 32'(ifa.q_count), 32'd0);
        adv();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            fetch_rdy      = vecs[i].rdy;
            fetch_data     = vecs[i].data;
            fetch_err      = 1'b0;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            iss_ready      = vecs[i].ird;
            @(negedge clk);
            $display("[TB] vec %0d req=%0b addr=%h valid=%0b pc=%h cause=%0d qc=%0d", i,
                     ifa.fetch_req, ifa.fetch_addr, ifa.iss_valid, ifa.iss_pc,
                     ifa.iss_cause, ifa.q_count);
            chk($sformatf("v%0d fetch_req", i), 32'(ifa.fetch_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d fetch_addr", i), ifa.fetch_addr, vecs[i].e_addr);
            chk($sformatf("v%0d iss_valid", i), 32'(ifa.iss_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d q_count", i), 32'(ifa.q_count), 32'(vecs[i].e_qc));
            chk($sformatf("v%0d iss_pc", i), ifa.iss_pc, vecs[i].e_pc);
            chk($sformatf("v%0d iss_ins", i), ifa.iss_ins, vecs[i].e_ins);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d cause_a", i), 32'(ifa.iss_cause), 32'(vecs[i].e_cause_a));
                chk($sformatf("v%0d cause_b", i), 32'(ifb.iss_cause), 32'(vecs[i].e_cause_b));
                chk($sformatf("v%0d iss_mem", i), 32'(ifa.iss_mem), 32'(vecs[i].e_mem));
            end
            adv();
        end

        // Redirect to 0x100 with 3 queued entries and a fetch completing in the same cycle.
        redirect_valid = 1'b1; redirect_pc = 32'h200; fetch_rdy = 1'b0; iss_ready = 1'b0;
        fetch_data = W_ADDI;
        adv();
        redirect_valid = 1'b0; fetch_rdy = 1'b1;
        adv(); adv(); adv();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        $display("[TB] redirect 0x100 with qc=%0d", ifa.q_count);
        chk("rd3 q_count", 32'(ifa.q_count), 32'd3);
        chk("rd3 fetch_req", 32'(ifa.fetch_req), 32'd1);
        chk("rd3 fetch_addr", ifa.fetch_addr, 32'h20C);
        chk("rd3 iss_pc", ifa.iss_pc, 32'h200);
        adv();
        redirect_valid = 1'b0; iss_ready = 1'b1;
        @(negedge clk);
        chk("rd3 flush q_count", 32'(ifa.q_count), 32'd0);
        chk("rd3 flush iss_valid", 32'(ifa.iss_valid), 32'd0);
        chk("rd3 new fetch_addr", ifa.fetch_addr, 32'h100);
        chk("rd3 new fetch_req", 32'(ifa.fetch_req), 32'd1);
        adv();
        @(negedge clk);
        chk("rd3 first iss_valid", 32'(ifa.iss_valid), 32'd1);
        chk("rd3 first iss_pc", ifa.iss_pc, 32'h100);
        chk("rd3 first cause", 32'(ifa.iss_cause), 32'd0);
        adv();

        // Misaligned redirect: one synthetic entry, then halt.
        redirect_valid = 1'b1; redirect_pc = 32'h102; iss_ready = 1'b0;
        adv();
        redirect_valid = 1'b0;
        @(negedge clk);
        $display("[TB] misaligned redirect 0x102");
        chk("mis fetch_req0", 32'(ifa.fetch_req), 32'd0);
        chk("mis q_count0", 32'(ifa.q_count), 32'd0);
        adv();
        @(negedge clk);
        chk("mis iss_valid", 32'(ifa.iss_valid), 32'd1);
        chk("mis iss_pc", ifa.iss_pc, 32'h102);
        chk("mis iss_cause", 32'(ifa.iss_cause), 32'd1);
        chk("mis iss_ins", ifa.iss_ins, 32'd0);
        chk("mis q_count1", 32'(ifa.q_count), 32'd1);
        chk("mis fetch_req1", 32'(ifa.fetch_req), 32'd0);
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            adv();
            @(negedge clk);
            chk($sformatf("mis halt%0d fetch_req", k), 32'(ifa.fetch_req), 32'd0);
            chk($sformatf("mis halt%0d iss_valid", k), 32'(ifa.iss_valid), 32'd0);
        end
        adv();

        // Access fault at 0x8; entries 0x0 and 0x4 still issue normally.
        redirect_valid = 1'b1; redirect_pc = 32'h0; iss_ready = 1'b0; fetch_rdy = 1'b1;
        adv();
        redirect_valid = 1'b0;
        adv(); adv();
        fetch_err = 1'b1;
        @(negedge clk);
        $display("[TB] fetch fault at %h", ifa.fetch_addr);
        chk("err fetch_addr", ifa.fetch_addr, 32'h8);
        chk("err fetch_req", 32'(ifa.fetch_req), 32'd1);
        adv();
        fetch_err = 1'b0; iss_ready = 1'b1;
        @(negedge clk);
        chk("err halt fetch_req", 32'(ifa.fetch_req), 32'd0);
        chk("err q_count", 32'(ifa.q_count), 32'd3);
        chk("err e0 pc", ifa.iss_pc, 32'h0);
        chk("err e0 cause", 32'(ifa.iss_cause), 32'd0);
        adv();
        @(negedge clk);
        chk("err e1 pc", ifa.iss_pc, 32'h4);
        chk("err e1 cause", 32'(ifa.iss_cause), 32'd0);
        adv();
        @(negedge clk);
        chk("err e2 pc", ifa.iss_pc, 32'h8);
        chk("err e2 cause", 32'(ifa.iss_cause), 32'd2);
        adv();
        @(negedge clk);
        chk("err drained iss_valid", 32'(ifa.iss_valid), 32'd0);
        chk("err drained fetch_req", 32'(ifa.fetch_req), 32'd0);
        adv();

        // Reset mid-transaction abandons the fetch without a push.
        redirect_valid = 1'b1; redirect_pc = 32'h40; fetch_rdy = 1'b0; iss_ready = 1'b0;
        adv();
        redirect_valid = 1'b0; fetch_rdy = 1'b1; rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset during fetch at 0x40");
        chk("midrst fetch_req", 32'(ifa.fetch_req), 32'd0);
        adv();
        rst = 1'b0; fetch_rdy = 1'b0;
        @(negedge clk);
        chk("midrst q_count", 32'(ifa.q_count), 32'd0);
        chk("midrst iss_valid", 32'(ifa.iss_valid), 32'd0);
        chk("midrst fetch_addr", ifa.fetch_addr, 32'h0);
        chk("midrst fetch_req", 32'(ifa.fetch_req), 32'd1);
        adv();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
